// File: rtl/bf16_sub_seq.sv
// bf16_sub_seq: multi-cycle bfloat16 subtractor, diff = a - b.
// Walks IDLE -> ALIGN -> EXEC -> (NORM)* -> DONE. NORM applies one left
// shift per cycle, so latency depends on the data. Rounding truncates, and
// exp==0 inputs are read as zero.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b              minuend and subtrahend {sign, exp, mant}
//   out_valid/out_ready result handshake; diff is held while out_valid is high
//   diff              registered result
//
// Optional feature macro: BF16_SUB_SPECIALS_EN
//   Defined:   NaN and inf operands are detected in ALIGN and resolved
//              directly (ALIGN -> DONE).
//   Undefined: exp all-ones inputs are treated as ordinary normal numbers.
//              Only overflow saturation to inf applies.
module bf16_sub_seq #(
  parameter int EXP_SIZE      = 8,
  parameter int MANTISSA_SIZE = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_SIZE+MANTISSA_SIZE:0] a,
  input  logic [EXP_SIZE+MANTISSA_SIZE:0] b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_SIZE+MANTISSA_SIZE:0] diff
);

  localparam int W  = 1 + EXP_SIZE + MANTISSA_SIZE;
  localparam int MW = MANTISSA_SIZE + 1;
  localparam logic [EXP_SIZE-1:0] EXP_ONES    = '1;
  localparam logic [EXP_SIZE-1:0] SHIFT_LIMIT = EXP_SIZE'(MW);
  localparam logic [EXP_SIZE:0]   EXP_ONE     = {{EXP_SIZE{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, DONE} state_t;

  state_t               stateQ, stateD;
  logic [W-1:0]         aQ, aD, bQ, bD;
  logic [EXP_SIZE:0]    expQ, expD;
  logic [MW-1:0]        manXQ, manXD, manYQ, manYD, magQ, magD;
  logic                 signQ, signD;
  logic                 inReadyQ, inReadyD, outValidQ, outValidD;
  logic [W-1:0]         diffQ, diffD;

  // bQ holds b with its sign already inverted, so the datapath always adds.
  logic                 signA, signB;
  logic [EXP_SIZE-1:0]  expA, expB;
  logic [MW-1:0]        fullA, fullB;

  assign signA = aQ[W-1];
  assign signB = bQ[W-1];
  assign expA  = aQ[W-2 -: EXP_SIZE];
  assign expB  = bQ[W-2 -: EXP_SIZE];
  assign fullA = (expA != '0) ? {1'b1, aQ[MANTISSA_SIZE-1:0]} : '0;
  assign fullB = (expB != '0) ? {1'b1, bQ[MANTISSA_SIZE-1:0]} : '0;

`ifdef BF16_SUB_SPECIALS_EN
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};
  logic nanA, nanB, infA, infB;
  assign nanA = (expA == EXP_ONES) && (aQ[MANTISSA_SIZE-1:0] != '0);
  assign nanB = (expB == EXP_ONES) && (bQ[MANTISSA_SIZE-1:0] != '0);
  assign infA = (expA == EXP_ONES) && (aQ[MANTISSA_SIZE-1:0] == '0);
  assign infB = (expB == EXP_ONES) && (bQ[MANTISSA_SIZE-1:0] == '0);
`endif

  // Right shift with truncation. Shifts past the mantissa width give zero.
  function automatic logic [MW-1:0] alignShift(input logic [MW-1:0] m,
                                               input logic [EXP_SIZE-1:0] sh);
    if (sh >= SHIFT_LIMIT) return '0;
    else                   return m >> sh;
  endfunction

  // Packs a normalized result. An exponent at or above all-ones saturates to inf.
  function automatic logic [W-1:0] packResult(input logic s,
                                              input logic [EXP_SIZE:0] e,
                                              input logic [MW-1:0] m);
    if (e >= {1'b0, EXP_ONES}) return {s, EXP_ONES, {MANTISSA_SIZE{1'b0}}};
    else                       return {s, e[EXP_SIZE-1:0], m[MANTISSA_SIZE-1:0]};
  endfunction

  logic [MW:0]       rawSum;
  logic              rawSign;
  logic [MW-1:0]     normMag;
  logic [EXP_SIZE:0] normExp;

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    stateD    = stateQ;
    aD        = aQ;
    bD        = bQ;
    expD      = expQ;
    manXD     = manXQ;
    manYD     = manYQ;
    magD      = magQ;
    signD     = signQ;
    inReadyD  = inReadyQ;
    outValidD = outValidQ;
    diffD     = diffQ;
    rawSum    = '0;
    rawSign   = 1'b0;
    normMag   = magQ << 1;
    normExp   = expQ - EXP_ONE;

    case (stateQ)
      IDLE: begin
        if (in_valid) begin
          aD       = a;
          bD       = {~b[W-1], b[W-2:0]};
          inReadyD = 1'b0;
          stateD   = ALIGN;
        end
      end

      ALIGN: begin
        stateD = EXEC;
        if (expA >= expB) begin
          expD  = {1'b0, expA};
          manXD = fullA;
          manYD = alignShift(fullB, expA - expB);
        end else begin
          expD  = {1'b0, expB};
          manXD = alignShift(fullA, expB - expA);
          manYD = fullB;
        end
`ifdef BF16_SUB_SPECIALS_EN
        // signB is the inverted b sign, so inf - inf with equal input signs
        // shows up here as differing signs.
        if (nanA || nanB || (infA && infB && (signA != signB))) begin
          diffD     = QNAN;
          outValidD = 1'b1;
          stateD    = DONE;
        end else if (infA) begin
          diffD     = {signA, EXP_ONES, {MANTISSA_SIZE{1'b0}}};
          outValidD = 1'b1;
          stateD    = DONE;
        end else if (infB) begin
          diffD     = {signB, EXP_ONES, {MANTISSA_SIZE{1'b0}}};
          outValidD = 1'b1;
          stateD    = DONE;
        end
`endif
      end

      EXEC: begin
        if (signA == signB) begin
          rawSum  = {1'b0, manXQ} + {1'b0, manYQ};
          rawSign = signA;
        end else if (manXQ >= manYQ) begin
          rawSum  = {1'b0, manXQ} - {1'b0, manYQ};
          rawSign = signA;
        end else begin
          rawSum  = {1'b0, manYQ} - {1'b0, manXQ};
          rawSign = signB;
        end
        outValidD = 1'b1;
        stateD    = DONE;
        if (rawSum[MW]) begin
          diffD = packResult(rawSign, expQ + EXP_ONE, rawSum[MW:1]);
        end else if (rawSum == '0) begin
          // Exact cancellation (and 0 - 0) always gives +0.
          diffD = '0;
        end else if (rawSum[MW-1]) begin
          diffD = packResult(rawSign, expQ, rawSum[MW-1:0]);
        end else begin
          magD      = rawSum[MW-1:0];
          signD     = rawSign;
          outValidD = 1'b0;
          stateD    = NORM;
        end
      end

      NORM: begin
        // One left shift per cycle. Exponent underflow flushes to +0.
        if (normExp == '0) begin
          diffD     = '0;
          outValidD = 1'b1;
          stateD    = DONE;
        end else if (normMag[MW-1]) begin
          diffD     = packResult(signQ, normExp, normMag);
          outValidD = 1'b1;
          stateD    = DONE;
        end else begin
          magD = normMag;
          expD = normExp;
        end
      end

      DONE: begin
        if (out_ready) begin
          outValidD = 1'b0;
          inReadyD  = 1'b1;
          stateD    = IDLE;
        end
      end

      default: stateD = IDLE;
    endcase
  end

  // State registers. Reset discards any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      aQ        <= '0;
      bQ        <= '0;
      expQ      <= '0;
      manXQ     <= '0;
      manYQ     <= '0;
      magQ      <= '0;
      signQ     <= 1'b0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      diffQ     <= '0;
    end else begin
      stateQ    <= stateD;
      aQ        <= aD;
      bQ        <= bD;
      expQ      <= expD;
      manXQ     <= manXD;
      manYQ     <= manYD;
      magQ      <= magD;
      signQ     <= signD;
      inReadyQ  <= inReadyD;
      outValidQ <= outValidD;
      diffQ     <= diffD;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign diff      = diffQ;

endmodule

// File: tb/tb_bf16_sub_seq.sv
// tb_bf16_sub_seq: scoreboard bench for bf16_sub_seq.
// The driver pushes {expected diff, expected latency, accept edge} when a
// pair is accepted. The monitor pops and compares at every output handoff.
// Latency counts the accepting edge as edge 1.
module tb_bf16_sub_seq;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, diff;

  typedef struct {
    logic [15:0] diff;
    int          lat;
    int          acceptEdge;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    int          lat;
  } vec_t;

  sb_t sbQ[$];
  sb_t monE;
  int  checks = 0;
  int  errors = 0;
  int  edgeCount = 0;
  int  riseEdge = 0;
  logic prevValid = 1'b0;

  bf16_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCount++;

  // Compares one value and counts the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: records when out_valid rises and checks each handoff against
  // the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) riseEdge = edgeCount;
      prevValid = out_valid;
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected output: got diff 0x%0h, expected none", diff);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("diff", 32'(diff), 32'(monE.diff));
          checkOutput("latency", 32'(riseEdge - monE.acceptEdge + 1), 32'(monE.lat));
        end
      end
    end
  end

  // Waits for in_ready (bounded), presents one pair, and records the expectation.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic [15:0] vd, input int lat,
                               input bit expectOut);
    int waited = 0;
    @(posedge clk); #1;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1 within 100 cycles");
      return;
    end
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    @(posedge clk); #1;
    if (expectOut) sbQ.push_back('{vd, lat, edgeCount});
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
  endtask

  // Waits until every expected result has been seen and the DUT is idle.
  task automatic waitIdle();
    int n = 0;
    while ((sbQ.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbQ.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d pending, expected 0", sbQ.size());
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: a, b, expected diff, expected latency.
    vecs.push_back('{16'h4040, 16'h3F80, 16'h4000, 3});  // 3 - 1
    vecs.push_back('{16'h3F80, 16'h3F80, 16'h0000, 3});  // exact cancel
    vecs.push_back('{16'h3F80, 16'h3F7F, 16'h3C00, 10}); // 7 NORM shifts
    vecs.push_back('{16'h3F80, 16'hBF80, 16'h4000, 3});  // effective add with carry
    vecs.push_back('{16'h7F7F, 16'hFF7F, 16'h7F80, 3});  // overflow to +inf
    vecs.push_back('{16'h3F80, 16'h4040, 16'hC000, 3});  // 1 - 3, b larger
    vecs.push_back('{16'h4000, 16'h3F80, 16'h3F80, 4});  // 2 - 1, one shift
    vecs.push_back('{16'hC040, 16'hBF80, 16'hC000, 3});  // -3 - -1
    vecs.push_back('{16'h4380, 16'h3FFF, 16'h4380, 3});  // shift of 8 drops b
    vecs.push_back('{16'h4300, 16'h3FFF, 16'h42FE, 4});  // shift of 7, truncated
    vecs.push_back('{16'h0100, 16'h00FF, 16'h0000, 5});  // underflow flush
    vecs.push_back('{16'h0000, 16'h0000, 16'h0000, 3});  // 0 - 0 is +0
`ifdef BF16_SUB_SPECIALS_EN
    vecs.push_back('{16'h7F80, 16'h7F80, 16'h7FC0, 2});
    vecs.push_back('{16'h7FC1, 16'h3F80, 16'h7FC0, 2});
    vecs.push_back('{16'h3F80, 16'h7F80, 16'hFF80, 2});
`else
    vecs.push_back('{16'h7F80, 16'h3F80, 16'h7F80, 3});  // all-ones exp treated as normal
`endif
    foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].lat, 1'b1);
    waitIdle();

    // Stall: out_ready low for 5 cycles, with extra in_valid pulses that must be ignored.
    out_ready = 1'b0;
    applyStimulus(16'h0000, 16'h3F80, 16'hBF80, 3, 1'b1);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("stall reach out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 16'h4040;
      b        = 16'h3F80;
      @(posedge clk); #1;
      checkOutput("stall diff", 32'(diff), 32'hBF80);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no phantom output", 32'(out_valid), 32'd0);

    // Reset during NORM: the transaction is dropped, and outputs change at once.
    applyStimulus(16'h3F80, 16'h3F7F, 16'h3C00, 10, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("busy before reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("no output after reset", 32'(out_valid), 32'd0);

    // Normal operation after reset.
    applyStimulus(16'h4040, 16'h3F80, 16'h4000, 3, 1'b1);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
